// File: rtl/raster_pkg.sv
// Shared definitions for the raster pixel link (streamer and window control).
// Holds the FSM state set, the RAM read latency and the width helpers.
package raster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } raster_state_e;

  // Frame-buffer RAM returns data this many cycles after the read enable.
  localparam int RD_LAT    = 1;
  // Cycles spent flushing the read pipeline after the final read issues.
  localparam int DRAIN_CYC = RD_LAT + 1;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int xs);
    return clog2_min1(xs * xs);
  endfunction

  function automatic int cnt_w(input int xs);
    return clog2_min1(xs);
  endfunction

endpackage

// File: rtl/raster_streamer_if.sv
// Frame-buffer read port plus the valid-qualified pixel stream.
// master = streamer side, slave = RAM / downstream side.
interface raster_streamer_if #(
  parameter int xs = 32,
  parameter int dw = 8
);
  localparam int aw = raster_pkg::addr_w(xs);
  localparam int cw = raster_pkg::cnt_w(xs);

  logic          oRdEn;
  logic [aw-1:0] oRdAddr;
  logic [dw-1:0] iRdData;
  logic          oValid;
  logic [dw-1:0] oData;
  logic [cw-1:0] oRow;
  logic [cw-1:0] oCol;
  logic          oFrameEnd;

  modport master (
    output oRdEn, oRdAddr, oValid, oData, oRow, oCol, oFrameEnd,
    input  iRdData
  );

  modport slave (
    input  oRdEn, oRdAddr, oValid, oData, oRow, oCol, oFrameEnd,
    output iRdData
  );

endinterface

// File: rtl/raster_pos_cnt.sv
// Valid-gated raster position counter: col wraps into row, row wraps at frame end.
// Outputs the position of the pixel currently qualified by adv_i.
module raster_pos_cnt import raster_pkg::*; #(
  parameter int xs = 32,
  parameter int cw = cnt_w(xs)
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [cw-1:0] row_o,
  output logic [cw-1:0] col_o,
  output logic          frame_end_o
);

  localparam logic [cw-1:0] LAST = cw'(xs - 1);

  logic [cw-1:0] row_q, row_d;
  logic [cw-1:0] col_q, col_d;
  logic          row_last, col_last;

  assign row_last = (row_q == LAST);
  assign col_last = (col_q == LAST);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + cw'(1);
      end else begin
        col_d = col_q + cw'(1);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o       = row_q;
  assign col_o       = col_q;
  assign frame_end_o = adv_i & row_last & col_last;

endmodule

// File: rtl/raster_streamer.sv
// Streams an xs*xs frame buffer out in raster order as a valid-only pixel stream.
// Reads a 1-cycle-latency RAM; iHold stalls read issue, in-flight reads still emerge.
module raster_streamer import raster_pkg::*; #(
  parameter int xs = 32,
  parameter int dw = 8,
  parameter int aw = addr_w(xs),
  parameter int cw = cnt_w(xs)
) (
  input  logic iCLK,
  input  logic iRSTn,
  input  logic iStart,
  input  logic iHold,
  raster_streamer_if.master bus,
  output logic oBusy,
  output logic oDone
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  localparam int             DCW       = clog2_min1(DRAIN_CYC);
  localparam logic [aw-1:0]  LAST_ADDR = aw'(xs * xs - 1);
  localparam logic [DCW-1:0] DRN_LAST  = DCW'(DRAIN_CYC - 1);

  logic [1:0]         state_q, state_d;
  logic [aw-1:0]      addr_q, addr_d;
  logic [DCW-1:0]     drn_q, drn_d;
  logic [RD_LAT+1:1]  vld_pipe_q;
  logic [dw-1:0]      data_q;
  logic               rd_en;
  logic               start_acc;

  // Hold gates issue in the same cycle so a held cycle costs exactly one slot.
  assign rd_en     = (state_q == RUN) & ~iHold;
  assign start_acc = (state_q == IDLE) & iStart;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drn_d   = drn_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = RUN;
          addr_d  = '0;
        end
      end
      RUN: begin
        if (rd_en) begin
          if (addr_q == LAST_ADDR) begin
            state_d = DRAIN;
            drn_d   = '0;
          end else begin
            addr_d = addr_q + aw'(1);
          end
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) state_d = DONE;
        else                   drn_d   = drn_q + DCW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset drops the read pipeline, so nothing in flight reaches oValid.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      drn_q      <= '0;
      vld_pipe_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drn_q      <= drn_d;
      vld_pipe_q <= {vld_pipe_q[RD_LAT:1], rd_en};
      if (vld_pipe_q[RD_LAT]) data_q <= bus.iRdData;
    end
  end

  raster_pos_cnt #(.xs(xs), .cw(cw)) u_pos (
    .iCLK        (iCLK),
    .iRSTn       (iRSTn),
    .clr_i       (start_acc),
    .adv_i       (vld_pipe_q[RD_LAT+1]),
    .row_o       (bus.oRow),
    .col_o       (bus.oCol),
    .frame_end_o (bus.oFrameEnd)
  );

  assign bus.oRdEn   = rd_en;
  assign bus.oRdAddr = addr_q;
  assign bus.oValid  = vld_pipe_q[RD_LAT+1];
  assign bus.oData   = data_q;
  assign oBusy       = (state_q != IDLE);
  assign oDone       = (state_q == DONE);

endmodule

// File: tb/tb_raster_streamer.sv
// Bench for raster_streamer: schedule-based reference model drives a vector table,
// plus hand sequences for reset and restart corner cases; xs=4 and xs=32 instances.
module tb_raster_streamer;

  typedef struct {
    bit rden; int addr; bit vld; int data; int row; int col;
    bit fe; bit busy; bit done;
  } obs_t;

  typedef struct { bit start; bit hold; obs_t exp; } vec_t;

  localparam int TMAX = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0, hold4 = 1'b0, start32 = 1'b0, hold32 = 1'b0;
  logic busy4, done4, busy32, done32;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem4 [16];
  vec_t tbl [TMAX];
  bit   st_a [TMAX];
  bit   hd_a [TMAX];

  always #5 clk = ~clk;

  raster_streamer_if #(.xs(4),  .dw(8)) b4 ();
  raster_streamer_if #(.xs(32), .dw(8)) b32 ();

  raster_streamer #(.xs(4), .dw(8)) dut4 (
    .iCLK(clk), .iRSTn(rst_n), .iStart(start4), .iHold(hold4),
    .bus(b4.master), .oBusy(busy4), .oDone(done4)
  );

  raster_streamer #(.xs(32), .dw(8)) dut32 (
    .iCLK(clk), .iRSTn(rst_n), .iStart(start32), .iHold(hold32),
    .bus(b32.master), .oBusy(busy32), .oDone(done32)
  );

  // Synchronous single-port RAMs, one cycle of read latency.
  always @(posedge clk) if (b4.oRdEn) b4.iRdData <= mem4[b4.oRdAddr];
  always @(posedge clk) if (b32.oRdEn) b32.iRdData <= 8'(b32.oRdAddr);

  task automatic chk(input string nm, input int c, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
    end
  endtask

  function automatic obs_t sample(input bit big);
    obs_t o;
    if (big) begin
      o.rden = b32.oRdEn; o.addr = int'(b32.oRdAddr); o.vld = b32.oValid;
      o.data = int'(b32.oData); o.row = int'(b32.oRow); o.col = int'(b32.oCol);
      o.fe = b32.oFrameEnd; o.busy = busy32; o.done = done32;
    end else begin
      o.rden = b4.oRdEn; o.addr = int'(b4.oRdAddr); o.vld = b4.oValid;
      o.data = int'(b4.oData); o.row = int'(b4.oRow); o.col = int'(b4.oCol);
      o.fe = b4.oFrameEnd; o.busy = busy4; o.done = done4;
    end
    return o;
  endfunction

  task automatic clr_stim();
    for (int i = 0; i < TMAX; i++) begin
      st_a[i] = 1'b0;
      hd_a[i] = 1'b0;
    end
  endtask

  // Reference schedule: an accepted start at s issues reads on every unheld cycle
  // from s+1 until xs*xs reads are out; pixel k appears 2 cycles after its read.
  // Busy spans s+1..last_read+3, done at last_read+3, next start from last_read+4.
  function automatic int build(input int xs, input bit big);
    obs_t z;
    int n = xs * xs;
    int free_at = 0;
    int last = 0;
    for (int c = 0; c < TMAX; c++) begin
      tbl[c].start = st_a[c];
      tbl[c].hold  = hd_a[c];
      tbl[c].exp   = z;
    end
    for (int s = 0; s < TMAX - n - 8; s++) begin
      if (st_a[s] && s >= free_at) begin
        int c = s + 1;
        int k = 0;
        while (k < n) begin
          if (!hd_a[c]) begin
            tbl[c].exp.rden = 1'b1;
            tbl[c].exp.addr = k;
            tbl[c+2].exp.vld  = 1'b1;
            tbl[c+2].exp.data = big ? (k % 256) : int'(mem4[k]);
            tbl[c+2].exp.row  = k / xs;
            tbl[c+2].exp.col  = k % xs;
            tbl[c+2].exp.fe   = (k == n - 1);
            k++;
          end
          c++;
        end
        for (int b = s + 1; b <= c + 2; b++) tbl[b].exp.busy = 1'b1;
        tbl[c+2].exp.done = 1'b1;
        free_at = c + 3;
        last = c + 2;
      end
    end
    return last;
  endfunction

  // Entered and left just after a rising edge; cycle 0 is the first applied row.
  task automatic run_tbl(input string nm, input bit big, input int len);
    obs_t o, e;
    for (int c = 0; c < len; c++) begin
      if (big) begin start32 = tbl[c].start; hold32 = tbl[c].hold; end
      else     begin start4  = tbl[c].start; hold4  = tbl[c].hold; end
      @(negedge clk);
      o = sample(big);
      e = tbl[c].exp;
      chk({nm, ".valid"}, c, int'(o.vld),  int'(e.vld));
      chk({nm, ".rden"},  c, int'(o.rden), int'(e.rden));
      chk({nm, ".busy"},  c, int'(o.busy), int'(e.busy));
      chk({nm, ".done"},  c, int'(o.done), int'(e.done));
      chk({nm, ".fend"},  c, int'(o.fe),   int'(e.fe));
      if (e.rden) chk({nm, ".addr"}, c, o.addr, e.addr);
      if (e.vld) begin
        chk({nm, ".data"}, c, o.data, e.data);
        chk({nm, ".row"},  c, o.row,  e.row);
        chk({nm, ".col"},  c, o.col,  e.col);
      end
      @(posedge clk);
      #1;
    end
    start4 = 1'b0; hold4 = 1'b0; start32 = 1'b0; hold32 = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    obs_t o = sample(1'b0);
    chk({nm, ".valid"}, 0, int'(o.vld),  0);
    chk({nm, ".rden"},  0, int'(o.rden), 0);
    chk({nm, ".addr"},  0, o.addr, 0);
    chk({nm, ".data"},  0, o.data, 0);
    chk({nm, ".row"},   0, o.row,  0);
    chk({nm, ".col"},   0, o.col,  0);
    chk({nm, ".fend"},  0, int'(o.fe),   0);
    chk({nm, ".busy"},  0, int'(o.busy), 0);
    chk({nm, ".done"},  0, int'(o.done), 0);
  endtask

  initial begin
    int last;
    for (int i = 0; i < 16; i++) mem4[i] = 8'(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain frame: valid 3..18, frame end 18, done 19.
    clr_stim(); st_a[0] = 1'b1;
    last = build(4, 1'b0);
    run_tbl("plain", 1'b0, last + 3);

    // Hold on cycles 5..7: gaps on 7..9, done moves to 22.
    clr_stim(); st_a[0] = 1'b1; hd_a[5] = 1'b1; hd_a[6] = 1'b1; hd_a[7] = 1'b1;
    last = build(4, 1'b0);
    run_tbl("hold3", 1'b0, last + 3);

    // Starts in RUN and DONE are dropped; the one at 20 opens a second frame.
    clr_stim(); st_a[0] = 1'b1; st_a[5] = 1'b1; st_a[19] = 1'b1; st_a[20] = 1'b1;
    last = build(4, 1'b0);
    run_tbl("restart", 1'b0, last + 3);

    // Hold across the whole first 50 cycles of RUN.
    clr_stim(); st_a[0] = 1'b1;
    for (int i = 1; i <= 50; i++) hd_a[i] = 1'b1;
    last = build(4, 1'b0);
    run_tbl("hold50", 1'b0, last + 3);

    // Mid-frame reset at cycle 10 for one cycle.
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("postrst.valid", 0, int'(b4.oValid), 0);
      chk("postrst.busy",  0, int'(busy4), 0);
      chk("postrst.rden",  0, int'(b4.oRdEn), 0);
    end
    @(posedge clk); #1;
    clr_stim(); st_a[0] = 1'b1;
    last = build(4, 1'b0);
    run_tbl("afterrst", 1'b0, last + 3);

    // Randomized holds, extra start pulses and RAM contents.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
      clr_stim();
      st_a[0] = 1'b1;
      for (int j = 0; j < 4; j++) st_a[$urandom_range(1, 60)] = 1'b1;
      for (int j = 0; j < 120; j++) hd_a[j] = ($urandom_range(0, 2) == 0);
      last = build(4, 1'b0);
      run_tbl("rand", 1'b0, last + 3);
    end

    // Full-size frame: 1024 pixels, done at cycle 1027.
    clr_stim(); st_a[0] = 1'b1;
    last = build(32, 1'b1);
    chk("big.donecyc", 0, last, 1027);
    run_tbl("big", 1'b1, last + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/raster_streamer.md
# raster_streamer

Frame-buffer reader that streams an xs×xs image out in raster order as a valid-qualified pixel stream. It is the transmit end of the pixel interface whose receive side is the sliding-window control: its oValid/oData drive that block's iValid/pixel inputs. It reads a synchronous single-port RAM with 1-cycle read latency, tags every pixel with its row/column, and flags frame end. The stream is valid-only, with no backpressure; gaps are created by iHold.

## Interface
- xs, 32, image width = height in pixels
- dw, 8, pixel width
- aw, $clog2(xs*xs) (10 at default), RAM address width
- cw, $clog2(xs) (5 at default), row/col counter width
- iCLK  in  1  clock, rising edge
- iRSTn  in  1  reset, asynchronous, active-low
- iStart  in  1  start-of-frame request; sampled only in IDLE
- iHold  in  1  pause; no new read is issued while high
- oRdEn  out  1  RAM read enable
- oRdAddr  out  aw  RAM read address
- iRdData  in  dw  RAM read data, valid 1 cycle after oRdEn
- oValid  out  1  pixel valid, single-cycle per pixel
- oData  out  dw  pixel value
- oRow, oCol  out  cw each  raster position of current oData
- oFrameEnd  out  1  high with the last pixel (row = col = xs-1)
- oBusy  out  1  high from RUN entry through DONE
- oDone  out  1  one-cycle pulse after the last pixel

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: iStart=1 -> RUN; read address counter cleared to 0.
  - RUN: each cycle with iHold=0, assert oRdEn and oRdAddr = addr, then addr+1. When the read for addr = xs*xs-1 issues -> DRAIN.
  - DRAIN: 2 cycles, flushing the read pipeline -> DONE.
  - DONE: oDone=1 for 1 cycle -> IDLE.
- iStart outside IDLE is ignored; no queueing.
- Read pipeline: stage 1 carries the issued-read flag alongside RAM access. Stage 2 registers iRdData into oData and asserts oValid.
- iHold=1: oRdEn=0 and the address holds. Reads already issued still emerge on oValid. iHold in DRAIN/DONE/IDLE has no effect.
- Output position counters:
  - Advance only on oValid.
  - oCol wraps xs-1 -> 0 and increments oRow.
  - oRow wraps xs-1 -> 0 at frame end.
  - Both are cleared on RUN entry.
- oFrameEnd = oValid & oRow==xs-1 & oCol==xs-1.
- Address arithmetic is unsigned aw bits; the final address xs*xs-1 never wraps inside a frame.
- Reset is valid at any time, including mid-frame. Everything clears and in-flight reads are discarded (no oValid after reset release until the next iStart).

## Timing
- Reset values: oRdEn=0, oRdAddr=0, oValid=0, oData=0, oRow=0, oCol=0, oFrameEnd=0, oBusy=0, oDone=0, state IDLE.
- Latency: iStart sampled at cycle 0 -> first oRdEn at cycle 1 -> first oValid at cycle 3 (read at t gives oValid at t+2).
- No hold, N = xs*xs:
  - Reads issue cycles 1..N.
  - oValid is high cycles 3..N+2, with oFrameEnd at N+2.
  - DRAIN occupies cycles N+1..N+2.
  - oDone at N+3.
  - oBusy high cycles 1..N+3.
  - A new iStart is accepted at N+4 or later.
- Each held cycle in RUN delays all later events by exactly 1 cycle and produces 1 oValid gap 2 cycles later.
- oValid, oData, oRow, oCol, oFrameEnd are registered outputs; oRdEn/oRdAddr are registered from FSM state.

## Structure
- Shared package (`raster_pkg`): state enum (IDLE/RUN/DRAIN/DONE), read-latency constant RD_LAT=1, helper for cw/aw derivation. The same package is used by the window control.
- One natural sub-module: `raster_pos_cnt`, the valid-gated row/col wrap counter with frame-end flag. It is reusable by the receiver side.

## Test plan
- xs=4, RAM preloaded with data = address. Pulse iStart at cycle 0 -> oValid cycles 3..18, data 0..15 in order, row/col (0,0)..(3,3), oFrameEnd at cycle 18, oDone at cycle 19, oBusy cycles 1..19.
- xs=4, iHold=1 during cycles 5-7 -> oValid low on cycles 7-9, all 16 pixels still delivered in order, oDone at cycle 22.
- iStart re-pulsed at cycles 5 and 19 (DONE) -> ignored, exactly 16 pixels. iStart at cycle 20 -> second frame starts, first oValid at cycle 23.
- iRSTn low for 1 cycle at cycle 10 -> all outputs 0 immediately, no oValid afterward, state IDLE. Next iStart gives a full frame starting at pixel 0.
- Default xs=32 -> 1024 pixels, oCol wraps at 31, oRow reaches 31, oFrameEnd only on pixel 1023, oDone at cycle 1027.
- iHold held high for all of RUN for 50 cycles, then released -> no oRdEn and no oValid while held; frame completes normally afterward.
